// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Elaboration-time 10^n; 64 bits so 10^DIGITS never wraps for sane DIGITS.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the output register and the 7-segment decoders.
interface bin_to_bcd_seq_if
  import bin_to_bcd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
);
  // Handshake: start is a single-cycle strobe that is accepted only when
  // busy=0 and the converter is idle; a start seen while busy is dropped,
  // never queued. done pulses for one cycle exactly when bcd/ovf change.
  logic                  start;
  logic [DATA_W-1:0]     value;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;
  state_t                state;

  modport master (
    output start, value,
    input  busy, done, ovf, bcd, state
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, bcd, state
  );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with saturation and overflow flag.
// Optional leading-zero blanking is enabled with the macro BIN_TO_BCD_BLANK_LZ_EN.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W:0]   POW10   = (DATA_W + 1)'(pow10(DIGITS));
  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(POW10 - 1'b1);

  if (pow10(DIGITS) - 64'd1 > ((64'd1 << DATA_W) - 64'd1)) begin : g_range_err
    $error("bin_to_bcd_seq: 10^DIGITS-1 does not fit in DATA_W bits");
  end

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  operand_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   bcd_final;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_next_q;
  logic               ovf_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               saturate;

  assign saturate = ({1'b0, bus.value} >= POW10);

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[4*k +: 4]),
      .dout (work_adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (count_q == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result as presented to the display; optionally blank leading zeros above digit 0.
  always_comb begin
    bcd_final = work_q;
`ifdef BIN_TO_BCD_BLANK_LZ_EN
    begin : blank_lz
      logic leading;
      leading = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (leading && (work_q[4*k +: 4] == 4'd0)) begin
          bcd_final[4*k +: 4] = BLANK_CODE;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_q  <= '0;
      work_q     <= '0;
      count_q    <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Pre-saturating keeps every digit <= 9 after the last shift.
            operand_q  <= saturate ? MAX_VAL : bus.value;
            ovf_next_q <= saturate;
            work_q     <= '0;
            count_q    <= CNT_W'(DATA_W - 1);
          end
        end
        SHIFT: begin
          {work_q, operand_q} <= {work_adj, operand_q} << 1;
          count_q             <= count_q - CNT_W'(1);
        end
        FINISH: begin
          bcd_q  <= bcd_final;
          ovf_q  <= ovf_next_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
  assign bus.bcd   = bcd_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (DATA_W=32, DIGITS=4).
module tb_bin_to_bcd_seq;
  import bin_to_bcd_pkg::*;

`ifdef BIN_TO_BCD_BLANK_LZ_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bin_to_bcd_seq_if #(.DATA_W(32), .DIGITS(4)) bus ();

  bin_to_bcd_seq #(.DATA_W(32), .DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle. Launches one conversion and follows it to done.
  task automatic convert(input string tag, input logic [31:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    logic [15:0] prev;
    int          cyc;
    int          busy_n;
    bit          hold_bad;
    prev     = bus.bcd;
    cyc      = 0;
    busy_n   = 0;
    hold_bad = 1'b0;
    bus.start = 1'b1;
    bus.value = v;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) busy_n++;
      if (!bus.done && (bus.bcd !== prev)) hold_bad = 1'b1;
    end while (!bus.done && cyc < 100);
    check({tag, "_done_lat"}, cyc, 34);
    check({tag, "_busy_cycles"}, busy_n, 33);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_bcd"}, bus.bcd, exp_bcd);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int          t [3];
    logic [15:0] r [3];
    int          idx;
    int          done_n;
    logic [15:0] got;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_bcd", bus.bcd, 16'h0000);
    check("rst_state", 64'(bus.state), 64'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    convert("v1234", 32'd1234, 16'h1234, 1'b0);
    convert("v9999", 32'd9999, 16'h9999, 1'b0);
    convert("v10000", 32'd10000, 16'h9999, 1'b1);
    convert("vmax", 32'hFFFF_FFFF, 16'h9999, 1'b1);
    convert("v0", 32'd0, BLANK ? 16'hFFF0 : 16'h0000, 1'b0);
    convert("v42", 32'd42, BLANK ? 16'hFF42 : 16'h0042, 1'b0);

    // start while busy is dropped
    bus.start = 1'b1;
    bus.value = 32'd1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'd7777;
    @(negedge clk);
    bus.start = 1'b0;
    done_n = 0;
    got    = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_n++;
        got = bus.bcd;
      end
    end
    check("ign_done_count", done_n, 1);
    check("ign_bcd", got, 16'h1234);
    check("ign_busy", bus.busy, 0);

    // back-to-back with start held high
    idx = 0;
    bus.start = 1'b1;
    bus.value = 32'd1;
    for (int c = 1; c <= 150 && idx < 3; c++) begin
      @(negedge clk);
      if (bus.done) begin
        t[idx] = c;
        r[idx] = bus.bcd;
        idx++;
        if (idx == 1) bus.value = 32'd20;
        if (idx == 2) bus.value = 32'd300;
        if (idx == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", idx, 3);
    if (idx == 3) begin
      check("b2b_t0", t[0], 34);
      check("b2b_gap1", t[1] - t[0], 34);
      check("b2b_gap2", t[2] - t[1], 34);
      check("b2b_r0", r[0], BLANK ? 16'hFFF1 : 16'h0001);
      check("b2b_r1", r[1], BLANK ? 16'hFF20 : 16'h0020);
      check("b2b_r2", r[2], BLANK ? 16'hF300 : 16'h0300);
    end
    repeat (40) @(negedge clk);

    // asynchronous reset in the middle of a conversion
    bus.start = 1'b1;
    bus.value = 32'd1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_bcd", bus.bcd, 16'h0000);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_state", 64'(bus.state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("mid_no_done", done_n, 0);
    check("mid_bcd_after", bus.bcd, 16'h0000);

    convert("v_after_rst", 32'd5678, 16'h5678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
